sad_sample_loader: RTL

- Upstream feeder for the 32-entry sum-of-absolute-differences datapath.
- Accepts a byte stream over a valid/ready handshake and writes one frame of DEPTH samples into the 32x8 register file's write port.
- Pulses `go` to start the datapath, then waits for its `done` before accepting the next frame.
- Counts completed frames.

---
 rtl/sad_pkg.sv | 16 +
 rtl/loader_addr_counter.sv | 26 ++
 rtl/sad_sample_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD datapath and its sample loader.
// Holds the loader FSM state encoding and the register-file geometry.
package sad_pkg;

    localparam int SAD_DEPTH  = 32;
    localparam int SAD_DATA_W = 8;
    localparam int SAD_ADDR_W = 5;

    typedef enum logic [1:0] {
        FILL,
        START,
        WAIT_LO,
        WAIT_HI
    } sad_state_e;

endpackage

// File: rtl/loader_addr_counter.sv
// Register-file write address counter for the SAD sample loader.
// Ports: clk, rst (sync, active high), clr, inc -> addr, tc (addr==DEPTH-1).
module loader_addr_counter #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    assign tc = (addr == ADDR_W'(DEPTH - 1));

    // Explicit wrap so a non power-of-two DEPTH still restarts at 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= tc ? '0 : addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/sad_sample_loader.sv
// Loads one DEPTH-sample frame into the SAD register file, pulses go, waits on done.
// Ports: Clk, Rst (sync, active high), in_valid/in_data/in_ready, wr_en/wr_addr/wr_data,
// go, done, busy, frame_cnt, err. Optional wait timeout: SAD_SAMPLE_LOADER_TIMEOUT_EN.
module sad_sample_loader
    import sad_pkg::*;
#(
    parameter int DEPTH   = SAD_DEPTH,
    parameter int DATA_W  = SAD_DATA_W,
    parameter int ADDR_W  = SAD_ADDR_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              go,
    input  logic              done,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              err
);

    sad_state_e        state;
    sad_state_e        state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              tc;
    logic              xfer;
    logic              finish;
    logic              abort;

    // Outputs are held inactive while Rst is asserted so nothing is written.
    assign in_ready = (state == FILL) && !Rst;
    assign xfer     = in_valid && in_ready;
    assign wr_en    = xfer;
    assign wr_addr  = addr;
    assign wr_data  = in_data;
    assign go       = (state == START) && !Rst;
    assign busy     = (state != FILL) && !Rst;
    assign finish   = (state == WAIT_HI) && done;

    loader_addr_counter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk  (Clk),
        .rst  (Rst),
        .clr  (abort),
        .inc  (xfer),
        .addr (addr),
        .tc   (tc)
    );

`ifdef SAD_SAMPLE_LOADER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              err_q;

    assign waiting = (state == WAIT_LO) || (state == WAIT_HI);

    // A completing done in the same cycle beats the timeout.
    assign abort = waiting && !finish
                && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (Rst || state == START) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            frame_cnt <= '0;
        end else if (finish) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (xfer && tc) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (abort) begin
                    state_nxt = FILL;
                end else if (!done) begin
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (done || abort) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

endmodule
